// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer for MULT/MULTU/DIV/DIVU beside the EX-stage ALU.
// Holds EX while the multiply or restoring divide runs, then writes HI/LO once.
module muldiv_ctrl #(
   parameter int         WIDTH    = 32,
   parameter int         MUL_LAT  = 2,
   parameter logic [4:0] OP_MULT  = 5'd24,
   parameter logic [4:0] OP_MULTU = 5'd25,
   parameter logic [4:0] OP_DIV   = 5'd26,
   parameter logic [4:0] OP_DIVU  = 5'd27
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid_e,
   input  logic [4:0]       alucontrol_e,
   input  logic [WIDTH-1:0] a_e,
   input  logic [WIDTH-1:0] b_e,
   input  logic             flush,
   input  logic             stall_ext,
   output logic             stall_o,
   output logic             hilo_we,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             busy_o
);

   localparam int CNT_MAX = (MUL_LAT > WIDTH - 1) ? MUL_LAT : WIDTH - 1;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic               sgn_q, sgn_d;
   logic               a_neg_q, a_neg_d;
   logic               b_neg_q, b_neg_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               is_mul, is_div, op_signed, start;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     rem_sh, diff;
   logic               q_bit;
   logic [WIDTH-1:0]   rem_nx, quo_nx, rem_fix, quo_fix;
   logic [2*WIDTH-1:0] a_ext, b_ext, prod;

   always_comb begin
      is_mul    = op_valid_e & ((alucontrol_e == OP_MULT) | (alucontrol_e == OP_MULTU));
      is_div    = op_valid_e & ((alucontrol_e == OP_DIV) | (alucontrol_e == OP_DIVU));
      op_signed = (alucontrol_e == OP_MULT) | (alucontrol_e == OP_DIV);
      // rst gating keeps stall_o low while reset is held even if EX shows an op
      start     = ~rst & (state_q == S_IDLE) & ~flush & (is_mul | is_div);
      a_mag     = (op_signed & a_e[WIDTH-1]) ? -a_e : a_e;
      b_mag     = (op_signed & b_e[WIDTH-1]) ? -b_e : b_e;

      // One restoring-divide step: quo_q shifts the dividend out and quotient bits in
      rem_sh  = {rem_q, quo_q[WIDTH-1]};
      diff    = rem_sh - {1'b0, opb_q};
      q_bit   = ~diff[WIDTH];
      rem_nx  = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo_nx  = {quo_q[WIDTH-2:0], q_bit};
      quo_fix = (a_neg_q ^ b_neg_q) ? -quo_nx : quo_nx;
      rem_fix = a_neg_q ? -rem_nx : rem_nx;

      // Low 2W bits of the product of extended operands give both signed and unsigned results
      a_ext = sgn_q ? {{WIDTH{opa_q[WIDTH-1]}}, opa_q} : {{WIDTH{1'b0}}, opa_q};
      b_ext = sgn_q ? {{WIDTH{opb_q[WIDTH-1]}}, opb_q} : {{WIDTH{1'b0}}, opb_q};
      prod  = a_ext * b_ext;

      state_d = state_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      sgn_d   = sgn_q;
      a_neg_d = a_neg_q;
      b_neg_d = b_neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               sgn_d   = op_signed;
               a_neg_d = op_signed & a_e[WIDTH-1];
               b_neg_d = op_signed & b_e[WIDTH-1];
               if (is_mul) begin
                  opa_d   = a_e;
                  opb_d   = b_e;
                  cnt_d   = CNT_W'(1);
                  state_d = S_MUL;
               end else if (b_e == '0) begin
                  hi_d    = a_e;
                  lo_d    = '1;
                  state_d = S_DONE;
               end else begin
                  quo_d   = a_mag;
                  opb_d   = b_mag;
                  rem_d   = '0;
                  cnt_d   = '0;
                  state_d = S_DIV;
               end
            end
         end
         S_MUL: begin
            if (cnt_q == MUL_LAST) begin
               hi_d    = prod[2*WIDTH-1:WIDTH];
               lo_d    = prod[WIDTH-1:0];
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DIV: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            if (cnt_q == DIV_LAST) begin
               hi_d    = rem_fix;
               lo_d    = quo_fix;
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            if (~stall_ext) state_d = S_IDLE;
         end
      endcase

      // A flush discards whatever is in flight, including a result not yet in DONE
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         sgn_q   <= 1'b0;
         a_neg_q <= 1'b0;
         b_neg_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         sgn_q   <= sgn_d;
         a_neg_q <= a_neg_d;
         b_neg_q <= b_neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign stall_o = start | (state_q == S_MUL) | (state_q == S_DIV);
   assign hilo_we = (state_q == S_DONE) & ~stall_ext & ~flush;
   assign busy_o  = (state_q != S_IDLE);
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed corner cases plus random ops against an arithmetic model.
module tb_muldiv_ctrl;

   localparam int         W        = 32;
   localparam int         ML       = 2;
   localparam logic [4:0] OP_MULT  = 5'd24;
   localparam logic [4:0] OP_MULTU = 5'd25;
   localparam logic [4:0] OP_DIV   = 5'd26;
   localparam logic [4:0] OP_DIVU  = 5'd27;

   logic         clk = 1'b0;
   logic         rst;
   logic         op_valid_e;
   logic [4:0]   alucontrol_e;
   logic [W-1:0] a_e, b_e;
   logic         flush, stall_ext;
   logic         stall_o, hilo_we, busy_o;
   logic [W-1:0] hi_o, lo_o;

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0] r_hi, r_lo;

   muldiv_ctrl #(
      .WIDTH(W), .MUL_LAT(ML),
      .OP_MULT(OP_MULT), .OP_MULTU(OP_MULTU), .OP_DIV(OP_DIV), .OP_DIVU(OP_DIVU)
   ) dut (
      .clk(clk), .rst(rst), .op_valid_e(op_valid_e), .alucontrol_e(alucontrol_e),
      .a_e(a_e), .b_e(b_e), .flush(flush), .stall_ext(stall_ext),
      .stall_o(stall_o), .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Arithmetic reference: HI/LO contents and stall length taken straight from the op's meaning
   task automatic ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] hi, output logic [31:0] lo, output int st);
      longint       sa, sb, q, r;
      logic [63:0]  p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op == OP_MULT || op == OP_MULTU) begin
         if (op == OP_MULT) p = 64'(sa * sb);
         else               p = 64'(a) * 64'(b);
         hi = p[63:32];
         lo = p[31:0];
         st = ML + 1;
      end else if (b == 0) begin
         hi = a;
         lo = 32'hFFFF_FFFF;
         st = 1;
      end else begin
         if (op == OP_DIV) begin
            q = sa / sb;
            r = sa % sb;
            hi = 32'(r);
            lo = 32'(q);
         end else begin
            hi = a % b;
            lo = a / b;
         end
         st = 33;
      end
   endtask

   // Presents one op in EX from posedge+1 and holds it until it leaves EX.
   task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int ext_hold, input bit rand_ext, input bit gap, input string tag,
                        output logic [31:0] got_hi, output logic [31:0] got_lo);
      logic [31:0] e_hi, e_lo;
      int e_st, st_cnt, we_cnt, ext_left;
      bit left;
      ref_model(op, a, b, e_hi, e_lo, e_st);
      op_valid_e = 1'b1; alucontrol_e = op; a_e = a; b_e = b;
      st_cnt = 0; we_cnt = 0; ext_left = ext_hold; left = 1'b0;
      got_hi = '0; got_lo = '0;
      for (int cyc = 0; cyc < 200 && !left; cyc++) begin
         #1;
         if (stall_o)           stall_ext = rand_ext ? 1'($urandom_range(0, 1)) : 1'b0;
         else if (ext_left > 0) begin stall_ext = 1'b1; ext_left--; end
         else                   stall_ext = 1'b0;
         #1;
         if (stall_o) st_cnt++;
         if (hilo_we) begin we_cnt++; got_hi = hi_o; got_lo = lo_o; end
         left = !stall_o && !stall_ext;
         @(posedge clk); #1;
      end
      op_valid_e = 1'b0; stall_ext = 1'b0;
      check({tag, "_left"}, 64'(left), 64'd1);
      check({tag, "_stall"}, 64'(st_cnt), 64'(e_st));
      check({tag, "_we_cnt"}, 64'(we_cnt), 64'd1);
      check({tag, "_hi"}, 64'(got_hi), 64'(e_hi));
      check({tag, "_lo"}, 64'(got_lo), 64'(e_lo));
      if (gap) begin
         #1;
         check({tag, "_idle_we"}, 64'(hilo_we), 64'd0);
         check({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [4:0] rop;
      rst = 1'b1; op_valid_e = 1'b1; alucontrol_e = OP_MULT;
      a_e = 32'h1234_5678; b_e = 32'h9; flush = 1'b0; stall_ext = 1'b0;
      #12;
      check("rst_stall", 64'(stall_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_we", 64'(hilo_we), 64'd0);
      check("rst_hi", 64'(hi_o), 64'd0);
      check("rst_lo", 64'(lo_o), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0; op_valid_e = 1'b0;
      @(posedge clk); #1;

      do_op(OP_DIVU, 100, 7, 0, 0, 1, "divu_100_7", r_hi, r_lo);
      check("divu_100_7_lo_k", 64'(r_lo), 64'd14);
      check("divu_100_7_hi_k", 64'(r_hi), 64'd2);
      do_op(OP_DIV, -32'sd7, 2, 0, 0, 1, "div_m7_2", r_hi, r_lo);
      check("div_m7_2_lo_k", 64'(r_lo), 64'hFFFF_FFFD);
      check("div_m7_2_hi_k", 64'(r_hi), 64'hFFFF_FFFF);
      do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, "div_ovf", r_hi, r_lo);
      check("div_ovf_lo_k", 64'(r_lo), 64'h8000_0000);
      check("div_ovf_hi_k", 64'(r_hi), 64'h0);
      do_op(OP_MULT, 32'hFFFF_FFFF, 2, 0, 0, 1, "mult_m1_2", r_hi, r_lo);
      check("mult_m1_2_hi_k", 64'(r_hi), 64'hFFFF_FFFF);
      check("mult_m1_2_lo_k", 64'(r_lo), 64'hFFFF_FFFE);
      do_op(OP_MULTU, 32'hFFFF_FFFF, 2, 0, 0, 1, "multu_max_2", r_hi, r_lo);
      check("multu_max_2_hi_k", 64'(r_hi), 64'h1);
      check("multu_max_2_lo_k", 64'(r_lo), 64'hFFFF_FFFE);
      do_op(OP_DIV, 32'h1234, 0, 0, 0, 1, "div_by0", r_hi, r_lo);
      check("div_by0_hi_k", 64'(r_hi), 64'h1234);
      do_op(OP_DIVU, 32'h1234, 0, 0, 0, 1, "divu_by0", r_hi, r_lo);
      check("divu_by0_lo_k", 64'(r_lo), 64'hFFFF_FFFF);
      do_op(OP_DIVU, 1000, 10, 5, 1, 1, "divu_ext5", r_hi, r_lo);
      do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 5, 1, 0, "mult_ext5_b2b", r_hi, r_lo);
      do_op(OP_DIV, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 0, 0, 1, "div_b2b", r_hi, r_lo);

      // Non-HI/LO op codes must not engage the block
      op_valid_e = 1'b1; alucontrol_e = 5'd3; a_e = 32'd5; b_e = 32'd6;
      #1;
      check("other_stall", 64'(stall_o), 64'd0);
      @(posedge clk); #1;
      check("other_busy", 64'(busy_o), 64'd0);
      op_valid_e = 1'b0;

      // Flush at divide iteration 10
      op_valid_e = 1'b1; alucontrol_e = OP_DIV; a_e = 32'd12345; b_e = 32'd17;
      repeat (11) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      #1;
      check("flush_we", 64'(hilo_we), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; op_valid_e = 1'b0;
      #1;
      check("flush_busy", 64'(busy_o), 64'd0);
      check("flush_stall", 64'(stall_o), 64'd0);
      check("flush_we_after", 64'(hilo_we), 64'd0);
      do_op(OP_DIVU, 9, 3, 0, 0, 1, "divu_after_flush", r_hi, r_lo);
      check("divu_9_3_lo_k", 64'(r_lo), 64'd3);
      check("divu_9_3_hi_k", 64'(r_hi), 64'd0);

      // Asynchronous reset in the middle of a divide
      op_valid_e = 1'b1; alucontrol_e = OP_DIV; a_e = 32'd1000; b_e = 32'd3;
      repeat (5) begin
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      check("mid_rst_stall", 64'(stall_o), 64'd0);
      check("mid_rst_busy", 64'(busy_o), 64'd0);
      check("mid_rst_we", 64'(hilo_we), 64'd0);
      check("mid_rst_hi", 64'(hi_o), 64'd0);
      check("mid_rst_lo", 64'(lo_o), 64'd0);
      op_valid_e = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0: rop = OP_MULT;
            1: rop = OP_MULTU;
            2: rop = OP_DIV;
            default: rop = OP_DIVU;
         endcase
         do_op(rop, pick_val(), pick_val(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $sformatf("rnd%0d", i), r_hi, r_lo);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
